neuron_writeback: RTL

// - Stage-4 sink of the MLP datapath. Consumes the done/out/out_neuron_addr/

---
 rtl/neuron_writeback_if.sv | 28 ++
 rtl/neuron_writeback.sv | 103 ++++++++++
 2 files changed

// File: rtl/neuron_writeback_if.sv
// Stage-4 result bundle plus neuron-RAM write port for neuron_writeback.
// The slave modport is the writeback block's view; master is the driver/RAM side.
interface neuron_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              done_4;
    logic [DATA_W-1:0] out_4;
    logic [ADDR_W-1:0] out_neuron_addr_4;
    logic              write_neuron_4;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              fifo_full;
    logic              overflow;
    logic              layer_done;

    modport slave (
        input  done_4, out_4, out_neuron_addr_4, write_neuron_4, mem_ready,
        output mem_we, mem_addr, mem_wdata, fifo_full, overflow, layer_done
    );

    modport master (
        output done_4, out_4, out_neuron_addr_4, write_neuron_4, mem_ready,
        input  mem_we, mem_addr, mem_wdata, fifo_full, overflow, layer_done
    );
endinterface

// File: rtl/neuron_writeback.sv
// Stage-4 sink: queues neuron results in a FIFO, writes them to neuron RAM and
// pulses layer_done once a layer has drained. Define NEURON_WB_RELU_EN to clamp negatives to 0.
module neuron_writeback #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    neuron_writeback_if.slave     wb,
    output logic [1:0]            o_dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_overflow;
    logic              w_mem_we;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic [DATA_W-1:0] w_push_data;

    // Write port: a transfer happens on every cycle with mem_we && mem_ready;
    // mem_addr/mem_wdata come from registered storage and hold while mem_ready=0.
    assign w_mem_we = (r_count != '0);
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop    = w_mem_we && wb.mem_ready;
    assign w_push   = wb.write_neuron_4 && (!w_full || w_pop);

`ifdef NEURON_WB_RELU_EN
    assign w_push_data = wb.out_4[DATA_W-1] ? '0 : wb.out_4;
`else
    assign w_push_data = wb.out_4;
`endif

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= wb.out_neuron_addr_4;
            r_data_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            if (wb.write_neuron_4 && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // The done marker waits until everything queued ahead of (or with) it has been written.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (wb.done_4) w_state_next = (w_count_next == '0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (w_count_next == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign wb.mem_we     = w_mem_we;
    assign wb.mem_addr   = w_mem_we ? r_addr_mem[r_rd_ptr] : '0;
    assign wb.mem_wdata  = w_mem_we ? r_data_mem[r_rd_ptr] : '0;
    assign wb.fifo_full  = w_full;
    assign wb.overflow   = r_overflow;
    assign wb.layer_done = (r_state == S_DONE);
    assign o_dbg_state   = r_state;
endmodule
